// File: rtl/uncache_unit_pkg.sv
// -----------------------------------------------------------------------------
// uncache_unit_pkg
// Shared definitions for the uncached access unit: FSM state encoding,
// transfer-size codes and the write-strobe to transfer-size mapping.
// -----------------------------------------------------------------------------
package uncache_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Stores already arrive lane-aligned, so the strobe pattern alone tells
    // the width. Patterns a well-behaved core never produces fall back to a
    // word transfer, which still writes exactly the strobed lanes.
    function automatic logic [1:0] wstrb_to_size(input logic [3:0] wstrb);
        case (wstrb)
            4'b0001, 4'b0010,
            4'b0100, 4'b1000: wstrb_to_size = SIZE_BYTE;
            4'b0011, 4'b1100: wstrb_to_size = SIZE_HALF;
            default:          wstrb_to_size = SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/uncache_unit_if.sv
// -----------------------------------------------------------------------------
// uncache_unit_if
// Request/response bus between the uncached access unit (master) and the
// AXI bridge (slave).
//   bus_req     master->slave  request valid
//   bus_wr      master->slave  1 = write, 0 = read
//   bus_size    master->slave  transfer size (0 byte, 1 half, 2 word)
//   bus_addr    master->slave  transfer address
//   bus_wdata   master->slave  write data
//   bus_wstrb   master->slave  write strobes (0000 for reads)
//   bus_addr_ok slave->master  request accepted this cycle
//   bus_data_ok slave->master  read data / write response this cycle
//   bus_rdata   slave->master  read data, valid with bus_data_ok
// -----------------------------------------------------------------------------
interface uncache_unit_if;

    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );

endinterface

// File: rtl/uncache_unit.sv
// -----------------------------------------------------------------------------
// uncache_unit
// Turns one uncached core data access into a single bus transaction and
// stalls the pipeline until it completes.
//   clk        core clock, rising edge
//   resetn     asynchronous active-low reset
//   en         uncached access request from the core
//   wen        byte write strobes, 0000 = read
//   size       read access size (0 byte, 1 half, 2 word)
//   addr       physical address
//   wdata      lane-aligned store data
//   stall_ext  stall from every other pipeline source
//   stallreq   stall request to the core
//   rdata      load result, held until the next read completes
//   bus        master side of the bridge bus
// -----------------------------------------------------------------------------
module uncache_unit
    import uncache_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic [3:0]            wen,
    input  logic [1:0]            size,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    input  logic                  stall_ext,
    output logic                  stallreq,
    output logic [31:0]           rdata,
    uncache_unit_if.master        bus
);

    state_t      state;
    logic        lat_wr;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;

    // The request is captured once in IDLE, already translated into bus
    // form, so the bus fields come straight from flops and stay stable for
    // as long as the bridge withholds addr_ok.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            lat_wr    <= 1'b0;
            lat_size  <= SIZE_BYTE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state     <= REQ;
                        lat_wr    <= |wen;
                        lat_size  <= (|wen) ? wstrb_to_size(wen) : size;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        lat_wstrb <= wen;
                    end
                end
                REQ: begin
                    if (bus.bus_addr_ok) state <= WAIT;
                end
                WAIT: begin
                    if (bus.bus_data_ok) begin
                        state <= DONE;
                        if (!lat_wr) rdata <= bus.bus_rdata;
                    end
                end
                DONE: begin
                    // While the rest of the pipeline is stalled the core keeps
                    // presenting the same access; parking here stops it from
                    // being issued a second time.
                    if (!stall_ext) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The stall must be raised in the very cycle the access is presented,
    // before any state has been captured, hence the en term.
    assign stallreq = ((state == IDLE) && en) || (state == REQ) || (state == WAIT);

    assign bus.bus_req   = (state == REQ);
    assign bus.bus_wr    = lat_wr;
    assign bus.bus_size  = lat_size;
    assign bus.bus_addr  = lat_addr;
    assign bus.bus_wdata = lat_wdata;
    assign bus.bus_wstrb = lat_wstrb;

endmodule
